// File: rtl/divider_balance_monitor_if.sv
// divider_balance_monitor_if: sample-pair input and block-result output bundle.
interface divider_balance_monitor_if #(parameter int W = 12);
  logic s_valid, s_ready, res_valid, res_ready, imbalance, imb_sticky;
  logic signed [W-1:0] p2_db, p3_db, avg2, avg3;
  logic [W-1:0] thr_db;
  logic signed [W:0] diff;
  logic [7:0] blk_cnt;
  modport master (
    output s_valid, p2_db, p3_db, thr_db, res_ready,
    input s_ready, res_valid, avg2, avg3, diff, imbalance, imb_sticky, blk_cnt
  );
  modport slave (
    input s_valid, p2_db, p3_db, thr_db, res_ready,
    output s_ready, res_valid, avg2, avg3, diff, imbalance, imb_sticky, blk_cnt
  );
endinterface

// File: rtl/divider_balance_monitor.sv
// divider_balance_monitor: block-averages paired divider port powers and flags imbalance.
module divider_balance_monitor #(
  parameter int W = 12,
  parameter int AVG_LOG2 = 4
) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  divider_balance_monitor_if.slave bus
);
  localparam int SW = W + AVG_LOG2;
  typedef enum logic {ACCUM, RESULT} state_e;
  state_e state_q, state_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic signed [SW-1:0] sum2_q, sum2_d, sum3_q, sum3_d, acc2, acc3, sh2, sh3;
  logic signed [W-1:0] avg2_q, avg2_d, avg3_q, avg3_d, new2, new3;
  logic signed [W:0] diff_q, diff_d, new_diff;
  logic [W:0] mag;
  logic imb_q, imb_d, sticky_q, sticky_d, new_imb, take, last;
  logic [7:0] blk_q, blk_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ACCUM;
    else state_q <= state_d;
  always_comb
    state_d = clr ? ACCUM :
              state_q == ACCUM ? (last ? RESULT : ACCUM) :
              (bus.res_ready ? ACCUM : RESULT);
  always_comb begin
    bus.s_ready = state_q == ACCUM;
    bus.res_valid = state_q == RESULT;
  end
  // The last sample of a block is folded in before the shift so the result lands one cycle later.
  always_comb begin
    take = bus.s_valid && state_q == ACCUM;
    last = take && cnt_q == '1;
    acc2 = sum2_q + SW'(bus.p2_db);
    acc3 = sum3_q + SW'(bus.p3_db);
    sh2 = acc2 >>> AVG_LOG2;
    sh3 = acc3 >>> AVG_LOG2;
    new2 = sh2[W-1:0];
    new3 = sh3[W-1:0];
    new_diff = (W+1)'(new2) - (W+1)'(new3);
    mag = new_diff[W] ? -new_diff : new_diff;
    new_imb = mag > {1'b0, bus.thr_db};
    cnt_d = (clr || last) ? '0 : take ? cnt_q + 1'b1 : cnt_q;
    sum2_d = (clr || last) ? '0 : take ? acc2 : sum2_q;
    sum3_d = (clr || last) ? '0 : take ? acc3 : sum3_q;
    avg2_d = (!clr && last) ? new2 : avg2_q;
    avg3_d = (!clr && last) ? new3 : avg3_q;
    diff_d = (!clr && last) ? new_diff : diff_q;
    imb_d = clr ? 1'b0 : last ? new_imb : imb_q;
    sticky_d = clr ? 1'b0 : sticky_q | (last & new_imb);
    blk_d = (!clr && last) ? blk_q + 8'd1 : blk_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      sum2_q <= '0;
      sum3_q <= '0;
      avg2_q <= '0;
      avg3_q <= '0;
      diff_q <= '0;
      imb_q <= 1'b0;
      sticky_q <= 1'b0;
      blk_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sum2_q <= sum2_d;
      sum3_q <= sum3_d;
      avg2_q <= avg2_d;
      avg3_q <= avg3_d;
      diff_q <= diff_d;
      imb_q <= imb_d;
      sticky_q <= sticky_d;
      blk_q <= blk_d;
    end
  assign bus.avg2 = avg2_q;
  assign bus.avg3 = avg3_q;
  assign bus.diff = diff_q;
  assign bus.imbalance = imb_q;
  assign bus.imb_sticky = sticky_q;
  assign bus.blk_cnt = blk_q;
endmodule
